// File: rtl/spiflash_arb.sv
// Two-master read arbiter in front of a single Wishbone flash read port.
// Round-robin on ties, per-transaction timeout, and a drain path for masters that abandon a read.
module spiflash_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        resetn,

    input  logic [31:0] m0_adr_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic        grant_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        req0;
    logic        req1;
    logic        win;
    logic [31:0] win_adr;
    logic        gnt_cyc;
    logic        expired;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^{m0_adr_i[31:24], m1_adr_i[31:24]};

    // A master whose completion is on the bus this cycle is still holding its
    // request; masking it stops the same read from being issued twice.
    assign req0 = m0_cyc_i & m0_stb_i & ~m0_ack_o & ~m0_err_o;
    assign req1 = m1_cyc_i & m1_stb_i & ~m1_ack_o & ~m1_err_o;

    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = ~grant_o;
        end
    end

    assign win_adr = win ? m1_adr_i : m0_adr_i;
    assign gnt_cyc = grant_o ? m1_cyc_i : m0_cyc_i;
    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            s_adr_o  <= 32'd0;
            s_cyc_o  <= 1'b0;
            s_stb_o  <= 1'b0;
            m0_dat_o <= 32'd0;
            m1_dat_o <= 32'd0;
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
            grant_o  <= 1'b1;
            busy_o   <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_o <= win;
                        s_adr_o <= {8'h00, win_adr[23:0]};
                        s_cyc_o <= 1'b1;
                        s_stb_o <= 1'b1;
                        cnt     <= 8'd0;
                        busy_o  <= 1'b1;
                        state   <= BUSY;
                    end
                end

                BUSY: begin
                    if (!gnt_cyc) begin
                        // Abandoned read: let the flash finish, but tell nobody.
                        if (s_ack_i || expired) begin
                            s_cyc_o <= 1'b0;
                            s_stb_o <= 1'b0;
                            busy_o  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            cnt   <= cnt + 8'd1;
                            state <= DRAIN;
                        end
                    end else if (s_ack_i) begin
                        if (grant_o) begin
                            m1_dat_o <= s_dat_i;
                            m1_ack_o <= 1'b1;
                        end else begin
                            m0_dat_o <= s_dat_i;
                            m0_ack_o <= 1'b1;
                        end
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else if (expired) begin
                        if (grant_o) begin
                            m1_err_o <= 1'b1;
                        end else begin
                            m0_err_o <= 1'b1;
                        end
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                DRAIN: begin
                    if (s_ack_i || expired) begin
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    s_cyc_o <= 1'b0;
                    s_stb_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spiflash_arb.sv
// Directed bench for spiflash_arb: a default-timeout instance and a TIMEOUT=4
// instance share one stimulus stream; each step checks the relevant instance.
module tb_spiflash_arb;

    logic        clk;
    logic        resetn;
    logic [31:0] m0_adr, m1_adr, s_dat;
    logic        m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack;

    logic [31:0] d_m0_dat, d_m1_dat, d_s_adr;
    logic        d_m0_ack, d_m0_err, d_m1_ack, d_m1_err, d_s_cyc, d_s_stb, d_grant, d_busy;
    logic [31:0] t_m0_dat, t_m1_dat, t_s_adr;
    logic        t_m0_ack, t_m0_err, t_m1_ack, t_m1_err, t_s_cyc, t_s_stb, t_grant, t_busy;

    int checks = 0;
    int errors = 0;

    spiflash_arb u_dut (
        .wb_clk_i(clk), .resetn(resetn),
        .m0_adr_i(m0_adr), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_dat_o(d_m0_dat), .m0_ack_o(d_m0_ack), .m0_err_o(d_m0_err),
        .m1_adr_i(m1_adr), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_dat_o(d_m1_dat), .m1_ack_o(d_m1_ack), .m1_err_o(d_m1_err),
        .s_adr_o(d_s_adr), .s_cyc_o(d_s_cyc), .s_stb_o(d_s_stb),
        .s_dat_i(s_dat), .s_ack_i(s_ack),
        .grant_o(d_grant), .busy_o(d_busy)
    );

    spiflash_arb #(.TIMEOUT(4)) u_t4 (
        .wb_clk_i(clk), .resetn(resetn),
        .m0_adr_i(m0_adr), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_dat_o(t_m0_dat), .m0_ack_o(t_m0_ack), .m0_err_o(t_m0_err),
        .m1_adr_i(m1_adr), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_dat_o(t_m1_dat), .m1_ack_o(t_m1_ack), .m1_err_o(t_m1_err),
        .s_adr_o(t_s_adr), .s_cyc_o(t_s_cyc), .s_stb_o(t_s_stb),
        .s_dat_i(s_dat), .s_ack_i(s_ack),
        .grant_o(t_grant), .busy_o(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        tick;
        tick;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        m0_adr = 32'd0; m1_adr = 32'd0; s_dat = 32'd0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        tick;
        tick;
        chk("rst_stb", {31'd0, d_s_stb}, 32'd0);
        chk("rst_cyc", {31'd0, d_s_cyc}, 32'd0);
        chk("rst_adr", d_s_adr, 32'd0);
        chk("rst_grant", {31'd0, d_grant}, 32'd1);
        chk("rst_busy", {31'd0, d_busy}, 32'd0);
        chk("rst_dat0", d_m0_dat, 32'd0);
        resetn = 1'b1;
        tick;

        // Single m0 read, slave acks three cycles into the transfer
        m0_adr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick;
        chk("r1_stb", {31'd0, d_s_stb}, 32'd1);
        chk("r1_adr", d_s_adr, 32'h0000_0100);
        chk("r1_grant", {31'd0, d_grant}, 32'd0);
        chk("r1_busy", {31'd0, d_busy}, 32'd1);
        tick;
        tick;
        s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
        chk("r1_noack_early", {31'd0, d_m0_ack}, 32'd0);
        tick;
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        chk("r1_ack", {31'd0, d_m0_ack}, 32'd1);
        chk("r1_dat", d_m0_dat, 32'hDEAD_BEEF);
        chk("r1_stb_low", {31'd0, d_s_stb}, 32'd0);
        chk("r1_m1_quiet", {29'd0, d_m1_ack, d_m1_err, d_m0_err}, 32'd0);
        chk("r1_m1_dat", d_m1_dat, 32'd0);
        tick;
        chk("r1_ack_once", {31'd0, d_m0_ack}, 32'd0);
        chk("r1_dat_keep", d_m0_dat, 32'hDEAD_BEEF);

        // Both masters held: round-robin m0, m1, m0, m1
        do_reset;
        m0_adr = 32'h0000_0010; m1_adr = 32'hFF00_0020;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rr_grant", {31'd0, d_grant}, {31'd0, i[0]});
            chk("rr_stb", {31'd0, d_s_stb}, 32'd1);
            chk("rr_adr", d_s_adr, i[0] ? 32'h0000_0020 : 32'h0000_0010);
            s_ack = 1'b1; s_dat = 32'h1000_0000 + i;
            tick;
            s_ack = 1'b0;
            if (i[0]) begin
                chk("rr_ack1", {31'd0, d_m1_ack}, 32'd1);
                chk("rr_dat1", d_m1_dat, 32'h1000_0000 + i);
            end else begin
                chk("rr_ack0", {31'd0, d_m0_ack}, 32'd1);
                chk("rr_dat0", d_m0_dat, 32'h1000_0000 + i);
            end
            chk("rr_gap", {31'd0, d_s_stb}, 32'd0);
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick;
        chk("rr_idle", {31'd0, d_s_stb}, 32'd0);

        // TIMEOUT=4 instance, slave never acks
        do_reset;
        m1_adr = 32'h0000_0300; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick;
        chk("to_stb", {31'd0, t_s_stb}, 32'd1);
        chk("to_grant", {31'd0, t_grant}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("to_hold", {30'd0, t_s_stb, t_m1_err}, 32'd2);
        end
        tick;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        chk("to_drop", {31'd0, t_s_stb}, 32'd0);
        chk("to_err", {31'd0, t_m1_err}, 32'd1);
        chk("to_noack", {31'd0, t_m1_ack}, 32'd0);
        chk("to_busy", {31'd0, t_busy}, 32'd0);
        tick;
        chk("to_err_once", {31'd0, t_m1_err}, 32'd0);
        m1_adr = 32'h0000_0304; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick;
        chk("to_next_adr", t_s_adr, 32'h0000_0304);
        s_ack = 1'b1; s_dat = 32'h1234_5678;
        tick;
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        chk("to_next_ack", {30'd0, t_m1_ack, t_m1_err}, 32'd2);
        chk("to_next_dat", t_m1_dat, 32'h1234_5678);

        // Ack on the same cycle the counter expires: ack wins
        do_reset;
        m0_adr = 32'h0000_0400; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick;
        tick;
        tick;
        tick;
        chk("race_pre", {30'd0, t_s_stb, t_m0_err}, 32'd2);
        s_ack = 1'b1; s_dat = 32'hA5A5_0001;
        tick;
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        chk("race_ack", {31'd0, t_m0_ack}, 32'd1);
        chk("race_noerr", {31'd0, t_m0_err}, 32'd0);
        chk("race_dat", t_m0_dat, 32'hA5A5_0001);

        // m1 abandons its read; flash data is drained, then pending m0 is served
        do_reset;
        m1_adr = 32'h0000_0040; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick;
        chk("dr_grant", {31'd0, d_grant}, 32'd1);
        m0_adr = 32'h0000_0050; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick;
        chk("dr_busy", {31'd0, d_busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("dr_hold", {30'd0, d_s_stb, d_m1_ack}, 32'd2);
        end
        s_ack = 1'b1; s_dat = 32'hBAD0_BAD0;
        tick;
        s_ack = 1'b0;
        chk("dr_stb_low", {31'd0, d_s_stb}, 32'd0);
        chk("dr_no_resp", {28'd0, d_m0_ack, d_m0_err, d_m1_ack, d_m1_err}, 32'd0);
        chk("dr_dat1", d_m1_dat, 32'd0);
        chk("dr_dat0", d_m0_dat, 32'd0);
        tick;
        chk("dr_m0_grant", {31'd0, d_grant}, 32'd0);
        chk("dr_m0_adr", d_s_adr, 32'h0000_0050);
        chk("dr_m0_stb", {31'd0, d_s_stb}, 32'd1);
        s_ack = 1'b1; s_dat = 32'h0BAD_F00D;
        tick;
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        chk("dr_m0_ack", {31'd0, d_m0_ack}, 32'd1);
        chk("dr_m0_dat", d_m0_dat, 32'h0BAD_F00D);
        tick;

        // Asynchronous reset in the middle of a transfer
        m1_adr = 32'h0000_0060; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick;
        tick;
        chk("ar_busy_pre", {31'd0, d_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("ar_stb", {30'd0, d_s_stb, d_s_cyc}, 32'd0);
        chk("ar_adr", d_s_adr, 32'd0);
        chk("ar_grant", {31'd0, d_grant}, 32'd1);
        chk("ar_busy", {31'd0, d_busy}, 32'd0);
        chk("ar_dat0", d_m0_dat, 32'd0);
        s_ack = 1'b1; s_dat = 32'h5555_AAAA;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick;
        resetn = 1'b1;
        tick;
        chk("ar_no_ack", {28'd0, d_m0_ack, d_m0_err, d_m1_ack, d_m1_err}, 32'd0);
        chk("ar_idle_ack_ignored", d_m1_dat, 32'd0);
        s_ack = 1'b0;
        m1_adr = 32'h0000_0064; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick;
        chk("ar_post_grant", {31'd0, d_grant}, 32'd1);
        chk("ar_post_adr", d_s_adr, 32'h0000_0064);
        s_ack = 1'b1; s_dat = 32'hCAFE_F00D;
        tick;
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        chk("ar_post_ack", {31'd0, d_m1_ack}, 32'd1);
        chk("ar_post_dat", d_m1_dat, 32'hCAFE_F00D);
        tick;
        chk("ar_post_ack_once", {31'd0, d_m1_ack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
